// File: rtl/mem_req_ctrl.sv
// Command-queued memory request controller: FIFO-buffered write/read/clear ops driven onto registered memory strobes.
// Latency: accept at E0, strobe E1-E2, read response valid from E3; writes/clears sustain one per cycle.
// Backpressure: req_ready drops when the command FIFO is full; rsp_ready low holds the FSM in RSP and stalls issue.

// Generic synchronous FIFO: head-of-queue presented combinationally, no write-to-read bypass.
// Latency: an entry pushed at edge N is visible at the head after edge N.
// Backpressure: full blocks push, empty blocks pop; simultaneous push/pop keeps the count.
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head_dat,
  output logic          empty,
  output logic          full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign head_dat = store[rd_ptr];

  // Payload storage needs no reset: the count gates what is ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module mem_req_ctrl #(
  parameter int width      = 32,
  parameter int Add_width  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [Add_width-1:0] req_addr,
  input  logic [width-1:0]     req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [width-1:0]     rsp_rdata,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic                 mem_clear,
  output logic [Add_width-1:0] mem_addr,
  output logic [width-1:0]     mem_wdata,
  input  logic [width-1:0]     mem_rdata,
  output logic                 busy,
  output logic                 err
);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef struct packed {
    logic [1:0]           op;
    logic [Add_width-1:0] addr;
    logic [width-1:0]     wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RSP     = 2'd3
  } state_e;

  state_e     state;
  logic [1:0] cur_op;
  cmd_t       push_cmd;
  cmd_t       head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_push;
  logic       fifo_pop;

  assign push_cmd  = '{op: req_op, addr: req_addr, wdata: req_wdata};
  assign req_ready = !fifo_full;
  // Gating on rst keeps commands offered during reset out of the queue.
  assign fifo_push = req_valid && req_ready && rst;
  // A new command may leave the queue from IDLE, or back-to-back behind a write/clear.
  assign fifo_pop  = rst && !fifo_empty &&
                     ((state == IDLE) || ((state == ISSUE) && (cur_op != OP_RD)));
  assign busy      = !fifo_empty || (state != IDLE);

  sync_fifo #(
    .DW    ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (push_cmd),
    .pop      (fifo_pop),
    .head_dat (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Sequencer: pops commands, drives one registered strobe per issue, and owns the read response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cur_op    <= OP_WR;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_clear <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      err       <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_clear <= 1'b0;
      case (state)
        IDLE, ISSUE: begin
          if ((state == ISSUE) && (cur_op == OP_RD)) begin
            state <= RD_WAIT;
          end else if (fifo_pop) begin
            if (head.op == OP_RSV) begin
              // Reserved ops vanish at the pop; the next command gets the following slot.
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              state     <= ISSUE;
              cur_op    <= head.op;
              mem_addr  <= head.addr;
              mem_wdata <= head.wdata;
              mem_wr_en <= (head.op == OP_WR);
              mem_rd_en <= (head.op == OP_RD);
              mem_clear <= (head.op == OP_CLR);
            end
          end else begin
            state <= IDLE;
          end
        end
        RD_WAIT: begin
          // Memory returns data one cycle after the read strobe; capture it exactly here.
          rsp_rdata <= mem_rdata;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // At most one memory strobe is ever active.
  a_strobe_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({mem_wr_en, mem_rd_en, mem_clear}));

  // A response is only presented while waiting for the consumer.
  a_rsp_in_rsp: assert property (@(posedge clk) disable iff (!rst)
    rsp_valid |-> (state == RSP));

  // Strobes only ever appear in the issue state.
  a_strobe_in_issue: assert property (@(posedge clk) disable iff (!rst)
    (mem_wr_en || mem_rd_en || mem_clear) |-> (state == ISSUE));

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: directed command vectors with hand-computed read data.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
// Strobe and response expectations are queued at command acceptance and popped by the monitor.
module tb_mem_req_ctrl;

  localparam logic [1:0] W = 2'b00;
  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] C = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [3:0]  req_addr = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic        mem_clear;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  mem_req_ctrl #(.width(32), .Add_width(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_clear (mem_clear),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err       (err)
  );

  // Memory model: registered read, clear wipes every word.
  logic [31:0] mem_arr [16];
  always @(posedge clk) begin
    if (mem_wr_en) mem_arr[mem_addr] <= mem_wdata;
    if (mem_clear) for (int i = 0; i < 16; i++) mem_arr[i] <= 32'd0;
    if (mem_rd_en) mem_rdata <= mem_arr[mem_addr];
  end

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        drv_q[$];
  vec_t        strb_q[$];
  logic [31:0] rsp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] a,
                              input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.op = op; v.addr = a; v.wdata = d; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of the request driver: books an accepted command, then offers the next one.
  task automatic tick();
    bit   acc;
    vec_t v;
    @(negedge clk);
    acc = req_valid && req_ready && rst;
    @(posedge clk);
    #1;
    if (acc && drv_q.size() > 0) begin
      v = drv_q.pop_front();
      if (v.op != X) strb_q.push_back(v);
      if (v.op == R) rsp_q.push_back(v.exp);
    end
    if (drv_q.size() > 0) begin
      req_valid = 1'b1;
      req_op    = drv_q[0].op;
      req_addr  = drv_q[0].addr;
      req_wdata = drv_q[0].wdata;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((drv_q.size() != 0 || strb_q.size() != 0 || rsp_q.size() != 0 || busy || rsp_valid)
           && n < 200) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(rsp_valid), 32'd1);
  endtask

  task automatic check_reset(input string p);
    check({p, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({p, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({p, "_wr_en"},     32'(mem_wr_en), 32'd0);
    check({p, "_rd_en"},     32'(mem_rd_en), 32'd0);
    check({p, "_clear"},     32'(mem_clear), 32'd0);
    check({p, "_mem_addr"},  32'(mem_addr), 32'd0);
    check({p, "_mem_wdata"}, mem_wdata, 32'd0);
    check({p, "_err"},       32'(err), 32'd0);
    check({p, "_busy"},      32'(busy), 32'd0);
  endtask

  // Monitor: every strobe and every presented response is matched against the scoreboard.
  initial begin : monitor
    vec_t        e;
    logic [31:0] exp_sel;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_wr_en || mem_rd_en || mem_clear) begin
          check("strobe_onehot", 32'($countones({mem_wr_en, mem_rd_en, mem_clear})), 32'd1);
          if (strb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_strobe: wr=%0b rd=%0b clr=%0b addr=%0d, none required, at %0t",
                     mem_wr_en, mem_rd_en, mem_clear, mem_addr, $time);
          end else begin
            e = strb_q.pop_front();
            exp_sel = (e.op == W) ? 32'd1 : (e.op == R) ? 32'd2 : 32'd4;
            check("strobe_kind", 32'({mem_clear, mem_rd_en, mem_wr_en}), exp_sel);
            if (e.op != C) check("strobe_addr", 32'(mem_addr), 32'(e.addr));
            if (e.op == W) check("strobe_wdata", mem_wdata, e.wdata);
          end
        end
        if (rsp_valid) begin
          if (rsp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_rsp: rdata=0x%0h, no read pending, at %0t", rsp_rdata, $time);
          end else begin
            check("rsp_rdata", rsp_rdata, rsp_q[0]);
            if (rsp_ready) void'(rsp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #90000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset values while rst is held low, then ready right after release.
    repeat (3) begin @(posedge clk); #1; end
    check_reset("rst");
    rst = 1'b1;
    tick();
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Write then read-back with minimum read latency.
    drv_q.push_back(mk(W, 4'd3, 32'hDEADBEEF, 32'd0));
    wait_idle("t1_wr");
    drv_q.push_back(mk(R, 4'd3, 32'd0, 32'hDEADBEEF));
    tick();
    tick();
    tick();
    check("t1_rd_strobe_E1", 32'(mem_rd_en), 32'd1);
    check("t1_rd_addr", 32'(mem_addr), 32'd3);
    tick();
    check("t1_rsp_low_E2", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_rsp_high_E3", 32'(rsp_valid), 32'd1);
    wait_idle("t1_rd");

    // Stalled read response with five writes behind it: FIFO fills, then writes burst.
    rsp_ready = 1'b0;
    drv_q.push_back(mk(R, 4'd3, 32'd0, 32'hDEADBEEF));
    for (int i = 0; i < 5; i++) drv_q.push_back(mk(W, 4'(4 + i), 32'hA0 + 32'(i), 32'd0));
    wait_rsp("t2_rsp_seen");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_no_wr_in_stall", 32'(mem_wr_en), 32'd0);
      check("t2_rsp_held", 32'(rsp_valid), 32'd1);
    end
    check("t2_ready_low_full", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    check("t2_no_wr_release", 32'(mem_wr_en), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_wr_burst", 32'(mem_wr_en), 32'd1);
    end
    tick();
    check("t2_wr_burst_end", 32'(mem_wr_en), 32'd0);
    wait_idle("t2");

    // Clear wipes memory between writes.
    drv_q.push_back(mk(W, 4'd2, 32'h1, 32'd0));
    drv_q.push_back(mk(C, 4'd0, 32'd0, 32'd0));
    drv_q.push_back(mk(R, 4'd2, 32'd0, 32'd0));
    drv_q.push_back(mk(W, 4'd5, 32'h55, 32'd0));
    drv_q.push_back(mk(R, 4'd5, 32'd0, 32'h55));
    drv_q.push_back(mk(R, 4'd3, 32'd0, 32'd0));
    wait_idle("t3");

    // Reserved op between two writes: dropped, err sticky.
    check("t4_err_before", 32'(err), 32'd0);
    drv_q.push_back(mk(W, 4'd9, 32'h11, 32'd0));
    drv_q.push_back(mk(X, 4'd7, 32'hBAD, 32'd0));
    drv_q.push_back(mk(W, 4'd10, 32'h22, 32'd0));
    wait_idle("t4_ops");
    check("t4_err_set", 32'(err), 32'd1);
    drv_q.push_back(mk(R, 4'd10, 32'd0, 32'h22));
    wait_idle("t4_rd");
    check("t4_err_sticky", 32'(err), 32'd1);

    // Reset while in RSP with three commands queued.
    rsp_ready = 1'b0;
    drv_q.push_back(mk(R, 4'd10, 32'd0, 32'h22));
    drv_q.push_back(mk(W, 4'd11, 32'h1, 32'd0));
    drv_q.push_back(mk(W, 4'd12, 32'h2, 32'd0));
    drv_q.push_back(mk(W, 4'd13, 32'h3, 32'd0));
    wait_rsp("t5_rsp_seen");
    tick();
    check("t5_busy_queued", 32'(busy), 32'd1);
    drv_q.delete();
    strb_q.delete();
    rsp_q.delete();
    rst       = 1'b0;
    req_valid = 1'b1;
    req_op    = W;
    req_addr  = 4'd14;
    req_wdata = 32'h77;
    @(posedge clk); #1;
    check_reset("t5");
    repeat (2) begin @(posedge clk); #1; end
    check("t5_req_ignored_busy", 32'(busy), 32'd0);
    check("t5_ready_in_reset", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t5_no_strobe", 32'({mem_wr_en, mem_rd_en, mem_clear}), 32'd0);
    end
    check("t5_idle_after", 32'(busy), 32'd0);

    // Normal operation resumes after reset.
    drv_q.push_back(mk(W, 4'd1, 32'h5A, 32'd0));
    drv_q.push_back(mk(R, 4'd1, 32'd0, 32'h5A));
    wait_idle("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have parameters: width, default 32, data width; Add_width, default 4, address width; FIFO_DEPTH, default 4, command FIFO entries.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  command offered.
REQ-005 SHALL have port req_ready  output  1  command FIFO can accept.
REQ-006 SHALL have port req_op  input  2  00 write, 01 read, 10 clear, 11 reserved.
REQ-007 SHALL have port req_addr  input  Add_width  command address.
REQ-008 SHALL have port req_wdata  input  width  write data.
REQ-009 SHALL have port rsp_valid  output  1  read data available.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes read data.
REQ-011 SHALL have port rsp_rdata  output  width  read data.
REQ-012 SHALL have ports mem_wr_en, mem_rd_en and mem_clear  output  1 each  memory strobes, registered.
REQ-013 SHALL have ports mem_addr  output  Add_width and mem_wdata  output  width  memory address and data, registered.
REQ-014 SHALL have port mem_rdata  input  width  memory read data, one-cycle registered latency after mem_rd_en.
REQ-015 SHALL have port busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-016 SHALL have port err  output  1  sticky, reserved op seen.

Function
REQ-017 SHALL buffer commands in a FIFO_DEPTH-entry FIFO; push on req_valid && req_ready; req_ready = (count < FIFO_DEPTH), with no bypass: full-and-popping still deasserts ready.
REQ-018 SHALL implement FSM states IDLE, ISSUE, RD_WAIT, RSP.
REQ-019 SHALL pop the FIFO head and load the mem_* registers only on entry to ISSUE; the pop is allowed from IDLE, or from ISSUE when the current op is write/clear, and requires a non-empty FIFO.
REQ-020 SHALL, in ISSUE, assert exactly one strobe for that cycle: write gives mem_wr_en=1 with mem_addr/mem_wdata, read gives mem_rd_en=1 with mem_addr, clear gives mem_clear=1.
REQ-021 SHALL drive all strobes 0 in IDLE, RD_WAIT and RSP; mem_addr/mem_wdata hold their last values.
REQ-022 SHALL move ISSUE(write/clear) to ISSUE when the FIFO is non-empty, else to IDLE; writes/clears sustain one per cycle.
REQ-023 SHALL move ISSUE(read) to RD_WAIT; at the end of RD_WAIT it SHALL capture mem_rdata into rsp_rdata and go to RSP.
REQ-024 SHALL hold rsp_valid=1 in RSP with rsp_rdata stable until rsp_ready=1, then go to IDLE; no command issues while in RD_WAIT or RSP.
REQ-025 SHALL have timing: accept at edge E0, issue strobe high between E1 and E2, read response rsp_valid high from E3 (minimum latency).
REQ-026 SHALL drop a reserved op (11) at pop, without strobes, set err=1 until reset, and treat it as IDLE for the next-state decision.
REQ-027 SHALL issue commands strictly in acceptance order.
REQ-028 SHALL process a FIFO push and pop in the same cycle with count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-029 SHALL keep rsp_valid and mem_* independent of mem_rdata except at the RD_WAIT capture edge.

Reset
REQ-030 SHALL, on rst=0 at a clock edge, set FSM=IDLE, FIFO empty (req_ready=1 the cycle after rst rises), rsp_valid=0, rsp_rdata=0, mem_wr_en=mem_rd_en=mem_clear=0, mem_addr=0, mem_wdata=0, err=0, busy=0.
REQ-031 SHALL, on reset mid-operation (any state, including RSP with rsp_valid=1), discard all queued commands and any pending read data with no further strobes.
REQ-032 SHALL ignore req_valid while rst=0.

Verification
REQ-033 Write 0xDEADBEEF to addr 3, then read addr 3 -> mem_wr_en one cycle with addr 3; later rsp_valid=1 with rsp_rdata=0xDEADBEEF, read accepted E0 gives rsp_valid at E3.
REQ-034 Five writes offered back-to-back with FIFO_DEPTH=4 and the FSM issuing -> one mem_wr_en per cycle, order preserved, req_ready low when count=4.
REQ-035 Read with rsp_ready=0 for 5 cycles followed by a queued write -> rsp_valid/rsp_rdata stable 5 cycles, no mem_wr_en until the cycle after rsp_ready=1.
REQ-036 Write 0x1 to addr 2, clear, read addr 2 -> mem_clear one cycle between the writes' strobes, rsp_rdata=0.
REQ-037 Reserved op between two writes -> err=1 sticky, only two mem_wr_en pulses, on consecutive issue opportunities.
REQ-038 rst=0 asserted while in RSP with 3 commands queued -> next cycle all outputs at reset values, no strobes afterwards until new requests.
